// File: rtl/rvfi_pkg.sv
// RVFI trace types shared by the core-side commit ports and the commit serializer.
package rvfi_pkg;

    localparam int RVFI_SERIAL_DROP_W = 32;

    typedef struct packed {
        logic        valid;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
    } rvfi_instr_t;

    typedef struct packed {
        rvfi_instr_t instr;
        logic [63:0] order;
        logic [31:0] cycle;
    } rvfi_serial_entry_t;

    // A trap-only retirement still has to reach the trace consumers.
    function automatic logic is_eligible(input rvfi_instr_t instr);
        return instr.valid || instr.trap;
    endfunction

endpackage

// File: rtl/rvfi_serial_compact.sv
// Compacts the eligible commit ports: count of eligible ports and, per slot k,
// the index of the k-th eligible port in ascending port order.
module rvfi_serial_compact #(
    parameter int NR = 2,
    localparam int NW = $clog2(NR + 1),
    localparam int IW = (NR > 1) ? $clog2(NR) : 1
) (
    input  logic [NR-1:0]         mask,
    output logic [NW-1:0]         n,
    output logic [NR-1:0][IW-1:0] idx
);

    always_comb begin
        n   = '0;
        idx = '0;
        for (int i = 0; i < NR; i++) begin
            if (mask[i]) begin
                for (int k = 0; k < NR; k++) begin
                    if (k == int'(n)) begin
                        idx[k] = IW'(i);
                    end
                end
                n = n + NW'(1);
            end
        end
    end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Buffers up to NR_COMMIT_PORTS RVFI retirements per cycle and replays them one per handshake.
// Optional enqueue cycle stamping is enabled by defining RVFI_SERIAL_CYCLE_EN.
module rvfi_commit_serializer
    import rvfi_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output rvfi_instr_t                         rvfi_o,
    output logic [63:0]                         order_o,
    output logic [31:0]                         cycle_o,
    output logic [$clog2(DEPTH):0]              count_o,
    output logic                                overflow_o,
    output logic [RVFI_SERIAL_DROP_W-1:0]       drop_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(NR_COMMIT_PORTS + 1);
    localparam int IW = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1;

    if (DEPTH < 2 || DEPTH < NR_COMMIT_PORTS || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rvfi_commit_serializer: DEPTH must be a power of 2 and >= NR_COMMIT_PORTS");
    end

    logic [NR_COMMIT_PORTS-1:0]          eligible;
    logic [NW-1:0]                       n;
    logic [NR_COMMIT_PORTS-1:0][IW-1:0]  idx;

    rvfi_serial_entry_t                  mem [DEPTH];
    rvfi_serial_entry_t                  last;
    rvfi_serial_entry_t                  head_entry;
    logic [PW-1:0]                       head;
    logic [PW-1:0]                       tail;
    logic [CW-1:0]                       count;
    logic [63:0]                         order_cnt;
    logic                                overflow;
    logic [RVFI_SERIAL_DROP_W-1:0]       drop_cnt;
    logic [RVFI_SERIAL_DROP_W:0]         drop_sum;
    logic [31:0]                         stamp;
    logic [31:0]                         free;
    logic [CW-1:0]                       add_n;
    logic                                pop;
    logic                                accept;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            eligible[i] = is_eligible(rvfi_i[i]);
        end
    end

    rvfi_serial_compact #(
        .NR (NR_COMMIT_PORTS)
    ) u_compact (
        .mask (eligible),
        .n    (n),
        .idx  (idx)
    );

    // Handshake: valid_o means the head entry is stable on rvfi_o/order_o/cycle_o;
    // it leaves the FIFO at the rising edge where valid_o && ready_i, and valid_o never
    // depends on ready_i. ready_i does feed the accept decision so a full FIFO can
    // take new retirements in the same cycle it is drained.
    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i;
    assign free    = 32'(DEPTH) - 32'(count) + 32'(pop);
    assign accept  = (32'(n) <= free);
    assign add_n   = accept ? CW'(n) : '0;
    assign drop_sum = {1'b0, drop_cnt} + (RVFI_SERIAL_DROP_W + 1)'(n);

`ifdef RVFI_SERIAL_CYCLE_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign stamp = cycle_cnt;
`else
    assign stamp = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i && accept) begin
            for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
                if (k < int'(n)) begin
                    mem[tail + PW'(k)] <= '{instr: rvfi_i[idx[k]],
                                            order: order_cnt + 64'(k),
                                            cycle: stamp};
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            order_cnt <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            last      <= '0;
        end else begin
            if (pop) begin
                last <= mem[head];
                head <= head + PW'(1);
            end
            if (accept) begin
                tail <= tail + PW'(n);
            end else begin
                // Whole cycle is dropped; order still advances so the gap is visible downstream.
                overflow <= 1'b1;
                drop_cnt <= drop_sum[RVFI_SERIAL_DROP_W] ? '1 : drop_sum[RVFI_SERIAL_DROP_W-1:0];
            end
            count     <= count + add_n - CW'(pop);
            order_cnt <= order_cnt + 64'(n);
        end
    end

    // Once empty, the last consumed head stays on the outputs (zero after reset).
    assign head_entry = valid_o ? mem[head] : last;

    assign rvfi_o     = head_entry.instr;
    assign order_o    = head_entry.order;
    assign cycle_o    = head_entry.cycle;
    assign count_o    = count;
    assign overflow_o = overflow;
    assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Directed and random stimulus for rvfi_commit_serializer with a scoreboard of expected entries.
// Expected cycle stamps follow RVFI_SERIAL_CYCLE_EN.
module tb_rvfi_commit_serializer;
    import rvfi_pkg::*;

    localparam int NR    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = $bits(rvfi_serial_entry_t);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ready;
    rvfi_instr_t [NR-1:0]   rvfi_in;
    logic                   valid;
    rvfi_instr_t            rvfi_out;
    logic [63:0]            order;
    logic [31:0]            cycle;
    logic [CW-1:0]          count;
    logic                   overflow;
    logic [31:0]            drop_cnt;

    int                     checks = 0;
    int                     errors = 0;
    logic [EW-1:0]          exp_q[$];

    int                     m_count;
    logic [63:0]            m_order;
    logic                   m_ovf;
    logic [31:0]            m_drop;
    logic [31:0]            m_cyc;

    rvfi_commit_serializer #(
        .NR_COMMIT_PORTS (NR),
        .DEPTH           (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rvfi_i     (rvfi_in),
        .valid_o    (valid),
        .ready_i    (ready),
        .rvfi_o     (rvfi_out),
        .order_o    (order),
        .cycle_o    (cycle),
        .count_o    (count),
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rvfi_instr_t mk(input logic v, input logic t, input logic [31:0] insn);
        rvfi_instr_t r;
        r          = '0;
        r.valid    = v;
        r.trap     = t;
        r.insn     = insn;
        r.pc_rdata = {insn[15:0], insn[31:16]};
        r.pc_wdata = insn + 32'd4;
        r.rd_addr  = insn[11:7];
        r.rd_wdata = ~insn;
        return r;
    endfunction

    function automatic rvfi_instr_t none();
        return mk(1'b0, 1'b0, 32'h0);
    endfunction

    // Scoreboard consumer: compare the head whenever the handshake completes at the next edge.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pop", valid, 1'b0);
            end else begin
                chk("head", {rvfi_out, order, cycle}, exp_q.pop_front());
            end
        end
    end

    task automatic step(input rvfi_instr_t p0, input rvfi_instr_t p1, input logic rdy);
        rvfi_instr_t lst[2];
        int          n;
        int          free;
        logic        pop;
        logic [31:0] stamp;
        rvfi_in[0] = p0;
        rvfi_in[1] = p1;
        ready      = rdy;
`ifdef RVFI_SERIAL_CYCLE_EN
        stamp = m_cyc;
`else
        stamp = '0;
`endif
        n = 0;
        if (p0.valid || p0.trap) begin lst[n] = p0; n++; end
        if (p1.valid || p1.trap) begin lst[n] = p1; n++; end
        pop  = (m_count != 0) && rdy;
        free = DEPTH - m_count + int'(pop);
        if (n <= free) begin
            for (int k = 0; k < n; k++) begin
                exp_q.push_back({lst[k], m_order + 64'(k), stamp});
            end
            m_count += n;
        end else begin
            m_ovf  = 1'b1;
            m_drop = (m_drop > 32'hFFFF_FFFF - 32'(n)) ? 32'hFFFF_FFFF : m_drop + 32'(n);
        end
        m_count -= int'(pop);
        m_order += 64'(n);
        m_cyc   += 32'd1;
        @(posedge clk);
        #1;
        chk("count", count, m_count);
        chk("valid", valid, m_count != 0);
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic idle(input logic rdy);
        step(none(), none(), rdy);
    endtask

    task automatic reset_pulse();
        rst        = 1'b1;
        ready      = 1'b1;
        rvfi_in[0] = mk(1'b1, 1'b0, 32'h0000_0513);
        rvfi_in[1] = mk(1'b1, 1'b0, 32'h0000_0593);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        rvfi_in    = '0;
        ready      = 1'b0;
        m_count    = 0;
        m_order    = '0;
        m_ovf      = 1'b0;
        m_drop     = '0;
        m_cyc      = '0;
        exp_q.delete();
        chk("rst_valid", valid, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_rvfi", rvfi_out, 0);
        chk("rst_order", order, 0);
        chk("rst_cycle", cycle, 0);
    endtask

    initial begin
        logic [31:0] exp_stamp;
        rst     = 1'b1;
        ready   = 1'b0;
        rvfi_in = '0;
        m_count = 0;
        m_order = '0;
        m_ovf   = 1'b0;
        m_drop  = '0;
        m_cyc   = '0;
        reset_pulse();

        // Two retirements in one cycle come out port 0 first.
        step(mk(1'b1, 1'b0, 32'h0000_0013), mk(1'b1, 1'b0, 32'h0010_0093), 1'b1);
        chk("pair_insn0", rvfi_out.insn, 32'h0000_0013);
        chk("pair_order0", order, 0);
        idle(1'b1);
        chk("pair_insn1", rvfi_out.insn, 32'h0010_0093);
        chk("pair_order1", order, 1);
        idle(1'b1);
        chk("pair_drained", valid, 1'b0);

        // Trap-only retirement on port 1.
        step(none(), mk(1'b0, 1'b1, 32'h0000_0073), 1'b1);
        chk("trap_trap", rvfi_out.trap, 1'b1);
        chk("trap_valid", rvfi_out.valid, 1'b0);
        chk("trap_order", order, 2);
        idle(1'b1);

        // Fill to DEPTH, then overflow.
        reset_pulse();
        step(mk(1'b1, 1'b0, 32'h1000_0001), mk(1'b1, 1'b0, 32'h1000_0002), 1'b0);
        step(mk(1'b1, 1'b0, 32'h1000_0003), mk(1'b1, 1'b0, 32'h1000_0004), 1'b0);
        chk("full_count", count, 4);
        step(mk(1'b1, 1'b0, 32'h1000_0005), none(), 1'b0);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drop", drop_cnt, 1);
        chk("ovf_count", count, 4);
        step(mk(1'b1, 1'b0, 32'h1000_0006), none(), 1'b1);
        chk("full_pushpop_count", count, 4);
        step(mk(1'b1, 1'b0, 32'h1000_0007), mk(1'b1, 1'b0, 32'h1000_0008), 1'b1);
        chk("free1_count", count, 3);
        chk("free1_drop", drop_cnt, 3);
        step(mk(1'b1, 1'b0, 32'h1000_0009), mk(1'b0, 1'b1, 32'h1000_000A), 1'b1);
        chk("free2_count", count, 4);
        idle(1'b1);
        chk("pre_rst_count", count, 3);
        chk("pre_rst_ovf", overflow, 1'b1);

        // Mid-stream reset flushes and restarts order at 0.
        reset_pulse();
        step(mk(1'b1, 1'b0, 32'h2000_0001), none(), 1'b0);
        chk("post_rst_order", order, 0);
        idle(1'b1);

        // Stamp of an entry enqueued on the 10th edge after reset release.
        reset_pulse();
        repeat (9) idle(1'b0);
        step(mk(1'b1, 1'b0, 32'h3000_0001), none(), 1'b0);
`ifdef RVFI_SERIAL_CYCLE_EN
        exp_stamp = 32'd9;
`else
        exp_stamp = 32'd0;
`endif
        chk("cycle_stamp", cycle, exp_stamp);
        idle(1'b1);

        // Random traffic including overflow and traps.
        repeat (80) begin
            rvfi_instr_t p[2];
            for (int i = 0; i < 2; i++) begin
                int sel;
                sel  = $urandom_range(0, 3);
                p[i] = (sel == 0) ? none() : mk(sel[0], sel[1], $urandom);
            end
            step(p[0], p[1], logic'($urandom_range(0, 2) != 0));
        end
        repeat (DEPTH + 2) idle(1'b1);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
